// File: rtl/axi_pkg.sv
// Shared defaults and the stored-entry layout for the AXI-stream FIFO.
package axi_pkg;

  localparam int AXI_T_DATA_BIT   = 128;
  localparam int AXI_T_USER_WIDTH = 16;

  // One buffered beat: sideband in the upper bits, payload below.
  typedef struct packed {
    logic [AXI_T_USER_WIDTH-1:0] user;
    logic [AXI_T_DATA_BIT-1:0]   data;
  } axi_beat_t;

endpackage

// File: rtl/axi_stream_fifo_if.sv
// One AXI-stream channel; master drives valid/data/user, slave drives ready.
interface axi_stream_fifo_if
  import axi_pkg::*;
#(
  parameter int DW = AXI_T_DATA_BIT,
  parameter int UW = AXI_T_USER_WIDTH
);
  logic          valid;
  logic          ready;
  logic [DW-1:0] data;
  logic [UW-1:0] user;

  modport master (output valid, output data, output user, input  ready);
  modport slave  (input  valid, input  data, input  user, output ready);
endinterface

// File: rtl/axi_fifo_mem.sv
// Entry storage: one synchronous write port, one asynchronous read port.
// Contents are deliberately not reset; occupancy tracking makes stale words invisible.
module axi_fifo_mem #(
  parameter int DEPTH = 8,
  parameter int W     = 144,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [W-1:0]  wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [W-1:0]  rdata_o
);
  logic [W-1:0] mem_q [DEPTH];

  // Write the accepted beat into its slot.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/axi_stream_fifo.sv
// Elastic AXI-stream buffer with first-word fall-through, occupancy level,
// registered almost-full flag and synchronous flush.
module axi_stream_fifo
  import axi_pkg::*;
#(
  parameter int T_DATA_BIT   = AXI_T_DATA_BIT,
  parameter int T_USER_WIDTH = AXI_T_USER_WIDTH,
  parameter int DEPTH        = 8,
  parameter int AFULL_THRESH = DEPTH - 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  axi_stream_fifo_if.slave           t,
  axi_stream_fifo_if.master          rx,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic                       almost_full
);
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int LVL_W  = $clog2(DEPTH+1);
  localparam int BEAT_W = T_DATA_BIT + T_USER_WIDTH;

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $fatal(1, "axi_stream_fifo: DEPTH must be a power of two >= 2");
  end
  if ((AFULL_THRESH < 1) || (AFULL_THRESH > DEPTH)) begin : g_bad_thresh
    $fatal(1, "axi_stream_fifo: AFULL_THRESH must be in 1..DEPTH");
  end

  logic             init_q;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             afull_q, afull_d;
  logic             push, pop;
  logic [BEAT_W-1:0] rd_beat;

  // Ready depends on registered state only, so rx_ready never ripples back to t_ready.
  assign t.ready  = init_q && (level_q != LVL_W'(DEPTH));
  assign rx.valid = (level_q != '0);

  // Flush wins over any handshake in the same cycle.
  assign push = t.valid && t.ready && !flush;
  assign pop  = rx.valid && rx.ready && !flush;

  axi_fifo_mem #(.DEPTH(DEPTH), .W(BEAT_W), .AW(PTR_W)) u_mem (
    .clk     (clk),
    .we_i    (push),
    .waddr_i (wr_ptr_q),
    .wdata_i ({t.user, t.data}),
    .raddr_i (rd_ptr_q),
    .rdata_o (rd_beat)
  );

  assign rx.data     = rd_beat[T_DATA_BIT-1:0];
  assign rx.user     = rd_beat[BEAT_W-1:T_DATA_BIT];
  assign level       = level_q;
  assign almost_full = afull_q;

  // Next pointers/level; almost_full is derived from the next level so it tracks level exactly.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   level_d = level_q + LVL_W'(1);
        2'b01:   level_d = level_q - LVL_W'(1);
        default: level_d = level_q;
      endcase
    end
    afull_d = (level_d >= LVL_W'(AFULL_THRESH));
  end

  // State registers; init_q holds t_ready low for the first cycle out of reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      init_q   <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      afull_q  <= 1'b0;
    end else begin
      init_q   <= 1'b1;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      afull_q  <= afull_d;
    end
  end
endmodule

// File: tb/tb_axi_stream_fifo.sv
// Randomized bench for axi_stream_fifo against a queue-based reference model.
module tb_axi_stream_fifo;
  import axi_pkg::*;

  localparam int DEPTH = 8;
  localparam int DW    = AXI_T_DATA_BIT;
  localparam int UW    = AXI_T_USER_WIDTH;
  localparam int AF    = DEPTH - 2;
  localparam int LW    = $clog2(DEPTH+1);

  logic          clk = 1'b0;
  logic          rst_n;
  logic          flush;
  logic [LW-1:0] level;
  logic          almost_full;

  axi_stream_fifo_if #(.DW(DW), .UW(UW)) t_if ();
  axi_stream_fifo_if #(.DW(DW), .UW(UW)) rx_if ();

  axi_stream_fifo #(
    .T_DATA_BIT(DW), .T_USER_WIDTH(UW), .DEPTH(DEPTH), .AFULL_THRESH(AF)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .t           (t_if),
    .rx          (rx_if),
    .level       (level),
    .almost_full (almost_full)
  );

  always #5 clk = ~clk;

  axi_beat_t mq[$];
  bit        m_init;
  int        checks, errors;
  bit        did_push, did_pop;

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] rnd_data();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Check all outputs against the model, then advance one clock and update the model.
  task automatic step();
    bit        exp_rdy, exp_vld;
    axi_beat_t b;
    exp_rdy = m_init && (mq.size() != DEPTH);
    exp_vld = (mq.size() != 0);
    chk("t_ready",  DW'(t_if.ready),   DW'(exp_rdy));
    chk("rx_valid", DW'(rx_if.valid),  DW'(exp_vld));
    chk("level",    DW'(level),        DW'(mq.size()));
    chk("afull",    DW'(almost_full),  DW'(mq.size() >= AF));
    if (exp_vld) begin
      chk("rx_data", rx_if.data,      mq[0].data);
      chk("rx_user", DW'(rx_if.user), DW'(mq[0].user));
    end
    did_push = rst_n && !flush && t_if.valid && exp_rdy;
    did_pop  = rst_n && !flush && rx_if.ready && exp_vld;
    b.data = t_if.data;
    b.user = t_if.user;
    @(posedge clk);
    if (!rst_n) begin
      mq.delete();
      m_init = 1'b0;
    end else begin
      if (flush) mq.delete();
      else begin
        if (did_pop)  void'(mq.pop_front());
        if (did_push) mq.push_back(b);
      end
      m_init = 1'b1;
    end
    #1;
  endtask

  task automatic fill_to(input int n);
    int g;
    g = 0;
    rx_if.ready = 1'b0;
    while (mq.size() < n && g < 50) begin
      t_if.valid = 1'b1;
      t_if.data  = rnd_data();
      t_if.user  = UW'($urandom);
      step();
      g++;
    end
    t_if.valid = 1'b0;
    chk("fill_to", DW'(mq.size()), DW'(n));
  endtask

  initial begin
    logic [DW-1:0] x1, fl, nw;
    int sent, cyc;
    checks = 0; errors = 0;
    rst_n = 1'b0; flush = 1'b0;
    t_if.valid = 1'b1; t_if.data = rnd_data(); t_if.user = UW'($urandom);
    rx_if.ready = 1'b0;
    @(posedge clk); #1;
    mq.delete(); m_init = 1'b0;

    // Reset held with t_valid high
    repeat (3) step();
    rst_n = 1'b1; t_if.valid = 1'b0;
    step();
    chk("init_ready", DW'(t_if.ready), DW'(1));

    // Fill 1..8, then one rejected push
    for (int i = 1; i <= DEPTH; i++) begin
      t_if.valid = 1'b1; t_if.data = DW'(i); t_if.user = UW'(16'h100 + i);
      step();
      if (i == AF - 1) chk("afull_below", DW'(almost_full), DW'(0));
      if (i == AF)     chk("afull_at",    DW'(almost_full), DW'(1));
    end
    t_if.data = DW'(9);
    step();
    chk("full_level", DW'(level), DW'(DEPTH));
    chk("full_ready", DW'(t_if.ready), DW'(0));
    t_if.valid = 1'b0; rx_if.ready = 1'b1;
    for (int i = 1; i <= DEPTH; i++) begin
      chk("drain_data", rx_if.data, DW'(i));
      chk("drain_user", DW'(rx_if.user), DW'(16'h100 + i));
      step();
    end
    chk("drain_empty", DW'(rx_if.valid), DW'(0));

    // Full with simultaneous pop: push rejected, accepted next cycle
    fill_to(DEPTH);
    x1 = rnd_data();
    rx_if.ready = 1'b1; t_if.valid = 1'b1; t_if.data = x1; t_if.user = 16'h5a5a;
    step();
    chk("fsp_level", DW'(level), DW'(DEPTH-1));
    chk("fsp_ready", DW'(t_if.ready), DW'(1));
    rx_if.ready = 1'b0;
    step();
    chk("fsp_refill", DW'(level), DW'(DEPTH));
    t_if.valid = 1'b0; rx_if.ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      if (i == DEPTH-1) chk("fsp_last", rx_if.data, x1);
      step();
    end

    // Streaming with random backpressure across pointer wrap
    sent = 0; cyc = 0;
    t_if.data = rnd_data(); t_if.user = UW'($urandom);
    while ((sent < 20 || mq.size() != 0) && cyc < 500) begin
      rx_if.ready = 1'($urandom_range(0, 1));
      t_if.valid  = (sent < 20);
      step();
      if (did_push) begin
        sent++;
        t_if.data = rnd_data(); t_if.user = UW'($urandom);
      end
      cyc++;
    end
    t_if.valid = 1'b0;
    chk("stream_timeout", DW'(cyc < 500), DW'(1));
    chk("stream_empty", DW'(level), DW'(0));

    // Flush at level 5 with a concurrent push
    fill_to(5);
    fl = rnd_data();
    flush = 1'b1; t_if.valid = 1'b1; t_if.data = fl;
    step();
    flush = 1'b0; t_if.valid = 1'b0;
    chk("flush_level", DW'(level), DW'(0));
    chk("flush_rxv",   DW'(rx_if.valid), DW'(0));
    chk("flush_ready", DW'(t_if.ready), DW'(1));
    nw = rnd_data();
    t_if.valid = 1'b1; t_if.data = nw;
    step();
    t_if.valid = 1'b0;
    chk("flush_first", rx_if.data, nw);
    rx_if.ready = 1'b1;
    step();

    // Reset pulse at level 4
    fill_to(4);
    rst_n = 1'b0; t_if.valid = 1'b1; t_if.data = rnd_data();
    step();
    chk("rst_level", DW'(level), DW'(0));
    chk("rst_ready", DW'(t_if.ready), DW'(0));
    rst_n = 1'b1; t_if.valid = 1'b0;
    step();
    chk("rst_ready_after", DW'(t_if.ready), DW'(1));
    chk("rst_rxv", DW'(rx_if.valid), DW'(0));
    nw = rnd_data();
    t_if.valid = 1'b1; t_if.data = nw; rx_if.ready = 1'b0;
    step();
    t_if.valid = 1'b0;
    chk("rst_first", rx_if.data, nw);
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/axi_stream_fifo.md
Name: axi_stream_fifo

Overview:
Parametrised AXI-stream buffer between a producer-side channel (t_*) and a consumer-side channel (rx_*). It supports configurable depth, data width and user width, an occupancy level output, a programmable almost-full flag and a synchronous flush. It sits between the host-side stream and the controller core and decouples their backpressure. It replaces the fixed 128/16-bit point-to-point link with an elastic buffer.

Parameters:
T_DATA_BIT, 128, data bus width in bits (>=8)
T_USER_WIDTH, 16, sideband user width in bits (>=1)
DEPTH, 8, number of entries; power of two, >=2
AFULL_THRESH, DEPTH-2, level at or above which almost_full asserts (1..DEPTH)

Ports:
clk  in  1  clock, all logic rising-edge
rst_n  in  1  synchronous active-low reset
flush  in  1  synchronous clear of buffer contents
t_valid  in  1  producer data valid
t_ready  out  1  FIFO can accept
t_data  in  T_DATA_BIT  producer data
t_user  in  T_USER_WIDTH  producer sideband
rx_valid  out  1  head entry valid
rx_ready  in  1  consumer accepts head
rx_data  out  T_DATA_BIT  head data
rx_user  out  T_USER_WIDTH  head sideband
level  out  $clog2(DEPTH+1)  current occupancy
almost_full  out  1  level >= AFULL_THRESH

Behaviour:
- Reset (rst_n low at clk edge): wr_ptr=rd_ptr=0, level=0, rx_valid=0, almost_full=0, t_ready=0. t_ready rises in the first cycle after rst_n is sampled high (registered init flag). Storage contents are not reset. rx_data/rx_user are don't-care while rx_valid=0.
- Reset mid-operation discards all entries. No partial transfer survives.
- Push = t_valid & t_ready. Pop = rx_valid & rx_ready. Both are evaluated at the same edge.
- t_ready = init_done & (level != DEPTH). It is driven from registered state only, with no combinational path from rx_ready.
- rx_valid = (level != 0). rx_data/rx_user = mem[rd_ptr]. First-word fall-through.
- Latency: a word pushed at edge N is presented on rx in cycle N+1 when the FIFO was empty. There is no same-cycle bypass.
- Pointers are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0. level updates as +1 on push only, -1 on pop only, and is unchanged on push&pop.
- Full (level==DEPTH): t_ready=0, so no push. A pop in the same cycle frees a slot, and t_ready rises the next cycle.
- Empty (level==0): rx_valid=0, so no pop. A push lands and level becomes 1.
- Push and pop together at 0<level<DEPTH: both pointers advance and level holds.
- Producer rule: t_data/t_user must be stable while t_valid=1 and t_ready=0. The FIFO guarantees the same on rx while rx_valid=1 and rx_ready=0.
- flush (rst_n high): has the same effect as reset on pointers, level, rx_valid and almost_full. A push in the flush cycle is dropped. t_ready stays 1. flush has priority over push/pop.
- almost_full is registered from the next-state level, so it is coincident with level.
- Parameter checks at elaboration: DEPTH power of two, and AFULL_THRESH in range. Either failure raises $fatal.

Decomposition:
- axi_pkg: default widths (T_DATA_BIT=128, T_USER_WIDTH=16) and a typedef for the {user,data} entry struct, axi_beat_t.
- Sub-module axi_fifo_mem: a DEPTH x (T_DATA_BIT+T_USER_WIDTH) register array with one write port and one async read port.
- The top module holds the pointers, level, flags and handshake logic.

Test Plan:
- Reset/init: hold rst_n=0 for 3 cycles with t_valid=1. Required: t_ready=0, rx_valid=0, level=0. Release rst_n; t_ready=1 one cycle later.
- Fill/drain, DEPTH=8: push data 0x1..0x8 with rx_ready=0. Required: level 8, t_ready=0, almost_full=1 from level 6. Then drain with rx_ready=1; required: 0x1..0x8 in order with matching user, rx_valid=0 after the 8th pop.
- Full with simultaneous pop: at level 8, rx_ready=1 and t_valid=1. Required: pop of head, push rejected that cycle, level 7. The next cycle t_ready=1, the push is accepted and level returns to 8.
- Streaming wrap: continuous push/pop of 20 words with random rx_ready (50%). Required: no loss or duplication, stable rx_data while stalled, correct pointer wrap.
- Flush: at level 5, assert flush for one cycle together with t_valid=1. Required: level 0, rx_valid=0 the next cycle, flushed data never appears, and the next push is output first.
- Reset mid-stream: at level 4, pulse rst_n=0 for one cycle. Required: level 0, no old data emitted, t_ready=0 during reset and 1 the cycle after.
